// File: rtl/intc_multimode.sv
// Multi-mode interrupt controller on the 5-bit/8-bit CSR bus.
// Each source has an enable, a pending bit, an edge/level trigger with polarity, and an optional synchronizer.

module intc_mm_chan #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic armed,
  input  logic src,
  input  logic typ,
  input  logic pol,
  input  logic mode_chg,
  input  logic w1c,
  output logic ip
);
  logic s, prev_q, prev_d, ip_q, ip_d, edge_hit;

  if (SYNC_STAGES > 0) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    always_comb sync_d = (sync_q << 1) | SYNC_STAGES'(src);
    always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= sync_d;
    end
    assign s = sync_q[SYNC_STAGES-1];
  end else begin : g_nosync
    assign s = src;
  end

  // prev always tracks s, so neither arming nor a mode change can fake an edge
  always_comb begin
    prev_d   = s;
    edge_hit = armed & (pol ? (s & ~prev_q) : (~s & prev_q));
    ip_d     = ip_q;
    if (mode_chg)      ip_d = 1'b0;
    else if (!typ)     ip_d = armed & (s == pol);
    else if (edge_hit) ip_d = 1'b1;
    else if (w1c)      ip_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      ip_q   <= 1'b0;
    end else begin
      prev_q <= prev_d;
      ip_q   <= ip_d;
    end
  end

  assign ip = ip_q;
endmodule

module intc_multimode #(
  parameter logic [4:0]          BASE_ADDR   = 5'h1c,
  parameter int                  NUM_INTS    = 7,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [NUM_INTS-1:0] DFL_TYPE    = '1,
  parameter logic [NUM_INTS-1:0] DFL_POL     = '0,
  parameter logic [NUM_INTS-1:0] DFL_IE      = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          csr_a,
  input  logic [7:0]          csr_di,
  input  logic                csr_we,
  output logic [7:0]          csr_do,
  input  logic [NUM_INTS-1:0] int_in,
  output logic                irq
);
  localparam int NB = (NUM_INTS + 7) / 8;
  localparam int NW = NB * 8;
  localparam logic [NW-1:0] VALID = NW'({NUM_INTS{1'b1}});

  logic [5:0]    off;
  logic          hit;
  logic [NW-1:0] ie_q, ie_d, type_q, type_d, pol_q, pol_d;
  logic [NW-1:0] ip, w1c, mode_chg;
  logic          armed_q, armed_d, irq_q, irq_d;

  // Reads reflect pre-write state; unimplemented bits are masked on both paths
  always_comb begin
    off    = {1'b0, csr_a} - {1'b0, BASE_ADDR};
    hit    = (csr_a >= BASE_ADDR) && (off < 6'(4 * NB));
    csr_do = 8'h00;
    ie_d   = ie_q;
    type_d = type_q;
    pol_d  = pol_q;
    w1c    = '0;
    for (int b = 0; b < NB; b++) begin
      if (hit && off[5:2] == 4'(b)) begin
        case (off[1:0])
          2'd0: begin
            csr_do = ie_q[8*b +: 8];
            if (csr_we) ie_d[8*b +: 8] = csr_di;
          end
          2'd1: begin
            csr_do = ip[8*b +: 8];
            if (csr_we) w1c[8*b +: 8] = csr_di;
          end
          2'd2: begin
            csr_do = type_q[8*b +: 8];
            if (csr_we) type_d[8*b +: 8] = csr_di;
          end
          default: begin
            csr_do = pol_q[8*b +: 8];
            if (csr_we) pol_d[8*b +: 8] = csr_di;
          end
        endcase
      end
    end
    ie_d     = ie_d & VALID;
    type_d   = type_d & VALID;
    pol_d    = pol_d & VALID;
    w1c      = w1c & VALID;
    mode_chg = (type_d ^ type_q) | (pol_d ^ pol_q);
    armed_d  = 1'b1;
    irq_d    = |(ip & ie_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q    <= NW'(DFL_IE);
      type_q  <= NW'(DFL_TYPE);
      pol_q   <= NW'(DFL_POL);
      armed_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      ie_q    <= ie_d;
      type_q  <= type_d;
      pol_q   <= pol_d;
      armed_q <= armed_d;
      irq_q   <= irq_d;
    end
  end

  for (genvar n = 0; n < NW; n++) begin : g_ch
    if (n < NUM_INTS) begin : g_src
      intc_mm_chan #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
        .clk      (clk),
        .rst      (rst),
        .armed    (armed_q),
        .src      (int_in[n]),
        .typ      (type_q[n]),
        .pol      (pol_q[n]),
        .mode_chg (mode_chg[n]),
        .w1c      (w1c[n]),
        .ip       (ip[n])
      );
    end else begin : g_pad
      assign ip[n] = 1'b0;
    end
  end

  assign irq = irq_q;
endmodule
